// File: rtl/tetron_collision_checker.sv
// tetron_collision_checker: walks the four tetron cells in order, bounds-checking each
// and reading the playfield, and reports the first out-of-bounds or occupied cell.
module tetron_collision_checker #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] anchor_row,
  input  logic [4:0] anchor_col,
  input  logic [4:0] blk1_voffset,
  input  logic [4:0] blk1_hoffset,
  input  logic [4:0] blk2_voffset,
  input  logic [4:0] blk2_hoffset,
  input  logic [4:0] blk3_voffset,
  input  logic [4:0] blk3_hoffset,
  input  logic [4:0] blk4_voffset,
  input  logic [4:0] blk4_hoffset,
  output logic       brd_rd_en,
  output logic [4:0] brd_rd_row,
  output logic [4:0] brd_rd_col,
  input  logic       brd_rd_data,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_collide,
  output logic       resp_oob,
  output logic [1:0] resp_blk
);
  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [4:0] a_row, a_col;
  logic [3:0][4:0] voff, hoff;
  logic [1:0] k;
  logic [4:0] row, col;
  logic oob;
  assign row = a_row + voff[k];
  assign col = a_col + hoff[k];
  // negative offsets wrap to large values and therefore land out of bounds
  assign oob = ({1'b0, row} >= 6'(ROWS)) || ({1'b0, col} >= 6'(COLS));
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign brd_rd_en = (state == CHECK) && !oob;
  assign brd_rd_row = brd_rd_en ? row : '0;
  assign brd_rd_col = brd_rd_en ? col : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? CHECK : IDLE;
      CHECK:   state_nx = oob ? RESP : WAIT;
      WAIT:    state_nx = (brd_rd_data || k == 2'd3) ? RESP : CHECK;
      default: state_nx = resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_row <= '0;
      a_col <= '0;
      voff <= '0;
      hoff <= '0;
      k <= '0;
      resp_collide <= 1'b0;
      resp_oob <= 1'b0;
      resp_blk <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        a_row <= anchor_row;
        a_col <= anchor_col;
        voff <= {blk4_voffset, blk3_voffset, blk2_voffset, blk1_voffset};
        hoff <= {blk4_hoffset, blk3_hoffset, blk2_hoffset, blk1_hoffset};
        k <= '0;
      end
      if (state == CHECK && oob) begin
        resp_oob <= 1'b1;
        resp_collide <= 1'b0;
        resp_blk <= k;
      end
      // a clean pass leaves all flags and the block index at zero
      if (state == WAIT) begin
        resp_collide <= brd_rd_data;
        resp_oob <= 1'b0;
        resp_blk <= brd_rd_data ? k : 2'd0;
        k <= k + 2'd1;
      end
      if (state == RESP && resp_ready) begin
        resp_collide <= 1'b0;
        resp_oob <= 1'b0;
        resp_blk <= '0;
      end
    end
endmodule

// File: tb/tb_tetron_collision_checker.sv
// tb_tetron_collision_checker: random and directed requests against a cell-walk model
// of the collision rules, with a per-cycle monitor of the playfield read port.
module tb_tetron_collision_checker;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_ready;
  logic [4:0] anchor_row = '0, anchor_col = '0;
  logic [4:0] blk1_voffset = '0, blk1_hoffset = '0, blk2_voffset = '0, blk2_hoffset = '0;
  logic [4:0] blk3_voffset = '0, blk3_hoffset = '0, blk4_voffset = '0, blk4_hoffset = '0;
  logic brd_rd_en, brd_rd_data = 1'b0, resp_valid, resp_ready = 1'b0;
  logic [4:0] brd_rd_row, brd_rd_col;
  logic resp_collide, resp_oob;
  logic [1:0] resp_blk;
  int n_checks = 0, n_fail = 0;
  bit board [32][32];
  logic [4:0] ar, ac;
  logic [4:0] v [4];
  logic [4:0] h [4];
  logic [9:0] exp_reads [$];
  logic exp_col, exp_oob;
  logic [1:0] exp_blk;
  int exp_lat;

  tetron_collision_checker #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .anchor_row(anchor_row), .anchor_col(anchor_col),
    .blk1_voffset(blk1_voffset), .blk1_hoffset(blk1_hoffset),
    .blk2_voffset(blk2_voffset), .blk2_hoffset(blk2_hoffset),
    .blk3_voffset(blk3_voffset), .blk3_hoffset(blk3_hoffset),
    .blk4_voffset(blk4_voffset), .blk4_hoffset(blk4_hoffset),
    .brd_rd_en(brd_rd_en), .brd_rd_row(brd_rd_row), .brd_rd_col(brd_rd_col),
    .brd_rd_data(brd_rd_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_collide(resp_collide), .resp_oob(resp_oob), .resp_blk(resp_blk)
  );

  always #5 clk = ~clk;

  // playfield memory: one-cycle read latency, junk when not reading
  always @(posedge clk)
    brd_rd_data <= brd_rd_en ? board[brd_rd_row][brd_rd_col] : 1'($urandom);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (brd_rd_en) begin
      chk("rd_expected", 32'(exp_reads.size() != 0), 1);
      if (exp_reads.size() != 0) begin
        e = exp_reads.pop_front();
        chk("rd_addr", {brd_rd_row, brd_rd_col}, e);
      end
      chk("rd_only_busy", req_ready | resp_valid, 0);
    end else chk("rd_idle_addr", {brd_rd_row, brd_rd_col}, 0);
  end

  task automatic model();
    logic [4:0] r, c;
    exp_reads.delete();
    exp_col = 0;
    exp_oob = 0;
    exp_blk = 0;
    exp_lat = 8;
    for (int i = 0; i < 4; i++) begin
      r = 5'(ar + v[i]);
      c = 5'(ac + h[i]);
      if (r >= ROWS || c >= COLS) begin
        exp_oob = 1; exp_blk = 2'(i); exp_lat = 2 * i + 1;
        return;
      end
      exp_reads.push_back({r, c});
      if (board[r][c]) begin
        exp_col = 1; exp_blk = 2'(i); exp_lat = 2 * i + 2;
        return;
      end
    end
  endtask

  task automatic set_req(input logic [4:0] r, c, v0, h0, v1, h1, v2, h2, v3, h3);
    ar = r; ac = c;
    v[0] = v0; h[0] = h0; v[1] = v1; h[1] = h1;
    v[2] = v2; h[2] = h2; v[3] = v3; h[3] = h3;
  endtask

  task automatic drive(input bit junk);
    anchor_row = junk ? 5'($urandom) : ar;
    anchor_col = junk ? 5'($urandom) : ac;
    blk1_voffset = junk ? 5'($urandom) : v[0];
    blk1_hoffset = junk ? 5'($urandom) : h[0];
    blk2_voffset = junk ? 5'($urandom) : v[1];
    blk2_hoffset = junk ? 5'($urandom) : h[1];
    blk3_voffset = junk ? 5'($urandom) : v[2];
    blk3_hoffset = junk ? 5'($urandom) : h[2];
    blk4_voffset = junk ? 5'($urandom) : v[3];
    blk4_hoffset = junk ? 5'($urandom) : h[3];
  endtask

  task automatic clear_board();
    foreach (board[r, c]) board[r][c] = 0;
  endtask

  task automatic accept();
    chk("req_ready_idle", req_ready, 1);
    drive(0);
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    drive(1);
  endtask

  task automatic run(input int hold);
    int lat;
    accept();
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("resp_collide", resp_collide, exp_col);
    chk("resp_oob", resp_oob, exp_oob);
    chk("resp_blk", resp_blk, exp_blk);
    chk("reads_left", exp_reads.size(), 0);
    chk("req_ready_busy", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_result", {resp_collide, resp_oob, resp_blk}, {exp_col, exp_oob, exp_blk});
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rd_en", brd_rd_en, 0);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("back_idle", req_ready, 1);
    chk("resp_dropped", resp_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {resp_valid, brd_rd_en, resp_collide, resp_oob, resp_blk}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clear_board();
    // empty board pass, held for three cycles before the handshake
    set_req(5, 4, 0, 0, 0, 1, 0, 31, 31, 31);
    model();
    chk("pin_pass_lat", exp_lat, 8);
    chk("pin_pass_rd3", exp_reads[3], {5'd4, 5'd3});
    run(3);
    board[5][5] = 1;
    model();
    chk("pin_hit_lat", exp_lat, 4);
    chk("pin_hit_n", exp_reads.size(), 2);
    run(0);
    clear_board();
    set_req(5, 0, 0, 0, 0, 1, 0, 31, 31, 31);
    model();
    chk("pin_oob_lat", exp_lat, 5);
    chk("pin_oob_blk", exp_blk, 2);
    run(1);
    set_req(19, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    model();
    chk("pin_corner_n", exp_reads.size(), 4);
    run(0);
    set_req(20, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    model();
    chk("pin_row20_lat", exp_lat, 1);
    run(0);
    // reset during the WAIT of the third block abandons the check
    set_req(5, 4, 0, 0, 0, 1, 0, 31, 31, 31);
    model();
    accept();
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_rd_en", brd_rd_en, 0);
    chk("mid_rst_ready", req_ready, 1);
    exp_reads.delete();
    @(posedge clk); #3 rst_n = 1;
    model();
    run(0);
    for (int t = 0; t < 150; t++) begin
      foreach (board[r, c]) board[r][c] = ($urandom_range(0, 11) == 0);
      ar = 5'($urandom_range(0, 23));
      ac = 5'($urandom_range(0, 12));
      for (int i = 0; i < 4; i++) begin
        v[i] = 5'($urandom_range(0, 6)) - 5'd3;
        h[i] = 5'($urandom_range(0, 6)) - 5'd3;
      end
      if ($urandom_range(0, 7) == 0) v[$urandom_range(0, 3)] = 5'($urandom);
      model();
      run($urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
